// File: rtl/instr_memory.sv
// instr_memory: loadable instruction memory that NOP-fills on reset, takes a program over
// a valid/ready port, then serves registered fetches with one cycle of latency.
module instr_memory #(
  parameter int INSTR_W = 17,
  parameter int ADDR_W = 8,
  parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               busy,
  input  logic               ld_start,
  input  logic               ld_valid,
  input  logic [INSTR_W-1:0] ld_data,
  output logic               ld_ready,
  input  logic               ld_done,
  output logic [ADDR_W:0]    ld_count,
  output logic               ld_ovf
);
  typedef enum logic [1:0] {INIT, RUN, LOAD} state_t;
  state_t state;
  logic [INSTR_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] clr_ptr;
  logic full, xfer, we;
  logic [ADDR_W-1:0] waddr;
  logic [INSTR_W-1:0] wdata;
  assign full = ld_count[ADDR_W];
  assign busy = state != RUN;
  assign ld_ready = state == LOAD && !full;
  // a restart in the same cycle takes priority over any word offered with it
  assign xfer = ld_ready && ld_valid && !ld_start;
  assign we = state == INIT || xfer;
  assign waddr = state == INIT ? clr_ptr : ld_count[ADDR_W-1:0];
  assign wdata = state == INIT ? NOP_WORD : ld_data;
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT;
      clr_ptr <= '0;
      instr <= NOP_WORD;
      instr_valid <= 1'b0;
      ld_count <= '0;
      ld_ovf <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (&clr_ptr) state <= RUN;
        end
        RUN: begin
          instr_valid <= fetch_en;
          if (fetch_en) instr <= mem[fetch_addr];
          if (ld_start) begin
            state <= LOAD;
            ld_count <= '0;
            ld_ovf <= 1'b0;
          end
        end
        LOAD: begin
          instr_valid <= 1'b0;
          if (ld_start) begin
            ld_count <= '0;
            ld_ovf <= 1'b0;
          end else begin
            if (xfer) ld_count <= ld_count + 1'b1;
            if (ld_valid && full) ld_ovf <= 1'b1;
          end
          if (ld_done && !ld_start) state <= RUN;
        end
        default: state <= INIT;
      endcase
    end
endmodule

// File: tb/tb_instr_memory.sv
// tb_instr_memory: directed test of init fill, loading, overflow, fetch latency and reset abort.
module tb_instr_memory;
  localparam int INSTR_W = 17;
  localparam int ADDR_W = 8;
  localparam int DEPTH = 256;
  logic clk = 0, rst_n = 0, fetch_en = 0, ld_start = 0, ld_valid = 0, ld_done = 0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic [INSTR_W-1:0] ld_data = '0, instr;
  logic instr_valid, busy, ld_ready, ld_ovf;
  logic [ADDR_W:0] ld_count;
  int checks = 0, errors = 0, cnt = 0;
  bit ovf_m = 0;
  logic [INSTR_W-1:0] model [DEPTH];
  logic [INSTR_W-1:0] prog [6] = '{17'h08421, 17'h10C63, 17'h11085, 17'h110A7, 17'h18800, 17'h1F0E0};

  instr_memory #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .NOP_WORD('0)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .instr(instr), .instr_valid(instr_valid), .busy(busy), .ld_start(ld_start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .ld_done(ld_done),
    .ld_count(ld_count), .ld_ovf(ld_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init();
    int n = 0;
    while (busy === 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check("init_cycles", n, DEPTH);
    check("init_valid", instr_valid, 0);
  endtask

  task automatic start_load();
    ld_start = 1;
    tick();
    ld_start = 0;
    cnt = 0;
    ovf_m = 0;
    check("start_count", ld_count, 0);
    check("start_ovf", ld_ovf, 0);
    check("start_busy", busy, 1);
  endtask

  task automatic xfer(input logic [INSTR_W-1:0] d, input bit v, input bit dn);
    ld_data = d;
    ld_valid = v;
    ld_done = dn;
    check("ld_ready", ld_ready, cnt < DEPTH);
    tick();
    ld_valid = 0;
    ld_done = 0;
    if (v) begin
      if (cnt < DEPTH) begin
        model[cnt] = d;
        cnt++;
      end else ovf_m = 1;
    end
  endtask

  task automatic fetch(input int a);
    fetch_addr = ADDR_W'(a);
    fetch_en = 1;
    tick();
    fetch_en = 0;
    check($sformatf("fetch_%0h", a), instr, model[a]);
    check("fetch_valid", instr_valid, 1);
  endtask

  initial begin
    foreach (model[i]) model[i] = '0;
    #12;
    check("rst_busy", busy, 1);
    check("rst_valid", instr_valid, 0);
    check("rst_ready", ld_ready, 0);
    check("rst_count", ld_count, 0);
    check("rst_ovf", ld_ovf, 0);
    check("rst_instr", instr, 0);
    rst_n = 1;
    wait_init();
    // test 1: fetch after NOP fill
    fetch(8'h37);
    tick();
    check("valid_drop", instr_valid, 0);
    check("instr_hold", instr, model[8'h37]);
    // test 2: ld_start alongside a fetch, which is still served
    fetch_addr = 8'h37;
    fetch_en = 1;
    model[8'h37] = '0;
    start_load();
    fetch_en = 0;
    check("start_fetch_valid", instr_valid, 1);
    for (int i = 0; i < 6; i++) xfer(prog[i], 1, 0);
    check("count6", ld_count, 6);
    xfer('0, 0, 1);
    check("run_busy", busy, 0);
    check("run_ready", ld_ready, 0);
    for (int i = 0; i <= 6; i++) begin
      fetch_addr = ADDR_W'(i);
      fetch_en = 1;
      tick();
      check($sformatf("pipe_%0d", i), instr, model[i]);
      check("pipe_valid", instr_valid, 1);
    end
    fetch_en = 0;
    check("count6_run", ld_count, 6);
    // test 3: valid gaps; address 5 keeps the word from the previous load
    start_load();
    for (int i = 0; i < 5; i++) begin
      xfer(INSTR_W'(17'h1AAA0 + i), 1, 0);
      for (int g = 0; g <= i % 3; g++) xfer('0, 0, 0);
      check("gap_count", ld_count, cnt);
    end
    xfer('0, 0, 1);
    for (int i = 0; i < 7; i++) fetch(i);
    check("gap_last_count", ld_count, 5);
    // test 4: overflow past DEPTH, fetch during LOAD suppressed
    start_load();
    fetch_addr = '0;
    fetch_en = 1;
    tick();
    fetch_en = 0;
    check("load_fetch_valid", instr_valid, 0);
    for (int i = 0; i < DEPTH + 1; i++) xfer(INSTR_W'(i * 3 + 1), 1, 0);
    check("ovf_flag", ld_ovf, ovf_m);
    check("ovf_count", ld_count, DEPTH);
    check("ovf_ready", ld_ready, 0);
    xfer('0, 0, 1);
    fetch(255);
    fetch(0);
    fetch(128);
    check("ovf_sticky", ld_ovf, 1);
    // test 5: third word arrives together with ld_done
    start_load();
    xfer(17'h0BEEF, 1, 0);
    xfer(17'h1CAFE, 1, 0);
    xfer(17'h05A5A, 1, 1);
    check("done_busy", busy, 0);
    check("done_count", ld_count, 3);
    fetch(2);
    fetch(3);
    // test 6: reset mid-LOAD aborts and refills with NOP
    start_load();
    for (int i = 0; i < 4; i++) xfer(INSTR_W'(17'h12340 + i), 1, 0);
    #2 rst_n = 0;
    #1;
    check("abort_busy", busy, 1);
    check("abort_count", ld_count, 0);
    check("abort_ready", ld_ready, 0);
    tick();
    tick();
    rst_n = 1;
    foreach (model[i]) model[i] = '0;
    wait_init();
    fetch(1);
    fetch(0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
